coef_stream_tx: RTL
===================

// Module: coef_stream_tx
// PURPOSE
// Transmit side of the FIR coefficient-load link. Holds a host-written bank of 64 signed Q15
//   coefficients and, on command, plays them out serially to the filter datapath's b input.
// Each load is framed as: filter reset window -> one dummy word -> 64 coefficient words.
// Sits on the coefficient clock domain (clk2), between the host register interface and the ALU.
// PARAMETERS
// NTAP     64  number of coefficients streamed per load (index width = 6)
// DW       16  coefficient width, signed two's complement
// RST_CYC  64  cycles alu_restn is held low before the dummy word (1..255)
// PORTS
// clk2         in   1      coefficient clock; all logic on posedge
// COEF_rest    in   1      synchronous reset, active-high
// wr_en        in   1      host write strobe, 1 cycle per word
// wr_addr      in   6      coefficient index 0..63
// wr_data      in   16     signed coefficient value
// wr_err       out  1      1-cycle pulse: write rejected (busy)
// start        in   1      begin a load frame (level sampled on posedge)
// busy         out  1      frame in progress (RST, PRE, SEND)
// alu_restn    out  1      active-low reset driven to filter datapath
// b            out  16     serial coefficient word to filter
// coef_loaded  out  1      last frame completed, bank unchanged since
// checksum     out  22     signed sum of the 64 words sent in the last frame
// BEHAVIOUR
// - All outputs registered. Under COEF_rest: state=IDLE, bank cleared to 0, b=0, busy=0,
//   alu_restn=0, coef_loaded=0, checksum=0, wr_err=0, counters=0. Reset mid-frame aborts
//   immediately; no partial frame resumes. First cycle after reset release: alu_restn=1.
// - FSM: IDLE -> RST -> PRE -> SEND -> DONE; DONE behaves as IDLE but coef_loaded=1.
//   IDLE/DONE: start=1 -> RST at next edge (cnt=0, checksum cleared, coef_loaded=0).
//   RST: alu_restn=0, b=0 for exactly RST_CYC cycles, then PRE.
//   PRE: alu_restn=1, b=0 (dummy word) for 1 cycle, then SEND with idx=0.
//   SEND: b=bank[idx], checksum+=bank[idx] (sign-extended to 22b), idx++;
//     after idx=NTAP-1 word -> DONE. No gaps, no backpressure.
//   DONE: b=0, coef_loaded=1, checksum stable until next start or reset.
// - Latency: start sampled cycle t -> alu_restn low t+1..t+RST_CYC; dummy at t+RST_CYC+1;
//   bank[k] on b at t+RST_CYC+2+k; coef_loaded=1 at t+RST_CYC+NTAP+2.
// - busy=1 in RST/PRE/SEND only. start while busy ignored (no restart, no error).
// - Writes: accepted in IDLE/DONE, committed at the edge wr_en is sampled. A write in DONE
//   clears coef_loaded (bank stale). wr_en while busy: bank untouched, wr_err=1 next cycle.
// - wr_en and start same cycle in IDLE: write is committed and is streamed in that frame.
// - Checksum range: 64 x [-32768,32767] fits 22b signed; no saturation, no wrap.
// TESTING
// 1 Reset, write bank[k]=k+1, start -> alu_restn low 64 cycles, b=0 once, then 1..64 in
//   order; coef_loaded=1, checksum=2080.
// 2 bank all 16'h8000, start -> every SEND word 0x8000, checksum=-2097152 (22'h200000).
// 3 wr_en at SEND idx=10 -> wr_err pulse 1 cycle, streamed word 10 and bank unchanged.
// 4 start asserted again at SEND idx=30 -> ignored; frame ends normally at idx 63.
// 5 COEF_rest at SEND idx=40 -> next cycle IDLE, b=0, alu_restn=0, busy=0, bank all 0.
// 6 DONE, write bank[5]=-7 -> coef_loaded=0; restart streams -7 at word 5, new checksum.

Source files
------------

// File: rtl/coef_stream_tx.sv
// coef_stream_tx: FIR coefficient-load transmitter.
// Holds a host-written bank of NTAP signed coefficients and, on start, plays
// a frame to the filter: RST_CYC cycles of alu_restn low, one dummy zero
// word, then bank[0..NTAP-1] back to back on b, accumulating a checksum.
module coef_stream_tx #(
  parameter int NTAP    = 64,
  parameter int DW      = 16,
  parameter int RST_CYC = 64,
  localparam int IW     = $clog2(NTAP),
  localparam int CW     = DW + IW
) (
  input  logic          clk2,
  input  logic          COEF_rest,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_err,
  input  logic          start,
  output logic          busy,
  output logic          alu_restn,
  output logic [DW-1:0] b,
  output logic          coef_loaded,
  output logic [CW-1:0] checksum
);

  typedef enum logic [2:0] {S_IDLE, S_RST, S_PRE, S_SEND, S_DONE} state_t;

  state_t        r_state;
  logic [7:0]    r_cnt;
  logic [IW-1:0] r_idx;
  logic [DW-1:0] r_bank [NTAP];

  logic [IW-1:0] w_rd_idx;
  logic [DW-1:0] w_rd_word;
  logic [CW-1:0] w_rd_ext;
  logic          w_last;

  // Word fetched for the next cycle: bank[0] when leaving PRE, else idx+1.
  always_comb begin
    w_rd_idx  = (r_state == S_PRE) ? '0 : r_idx + IW'(1);
    w_rd_word = r_bank[w_rd_idx];
    w_rd_ext  = {{IW{w_rd_word[DW-1]}}, w_rd_word};
    w_last    = (r_idx == IW'(NTAP - 1));
  end

  // Frame sequencer, coefficient bank and all registered outputs.
  always_ff @(posedge clk2) begin
    if (COEF_rest) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      for (int i = 0; i < NTAP; i++) r_bank[i] <= '0;
      b           <= '0;
      busy        <= 1'b0;
      alu_restn   <= 1'b0;
      coef_loaded <= 1'b0;
      checksum    <= '0;
      wr_err      <= 1'b0;
    end else begin
      // Busy writes are dropped; the error pulse lands one cycle later.
      wr_err <= wr_en && busy;
      case (r_state)
        S_IDLE, S_DONE: begin
          alu_restn <= 1'b1;
          b         <= '0;
          if (wr_en) begin
            r_bank[wr_addr] <= wr_data;
            coef_loaded     <= 1'b0;  // bank no longer matches last frame
          end
          if (start) begin
            r_state     <= S_RST;
            r_cnt       <= '0;
            checksum    <= '0;
            coef_loaded <= 1'b0;
            busy        <= 1'b1;
            alu_restn   <= 1'b0;
          end
        end
        S_RST: begin
          if (r_cnt == 8'(RST_CYC - 1)) begin
            r_state   <= S_PRE;
            alu_restn <= 1'b1;       // dummy word cycle, b stays 0
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_PRE: begin
          r_state  <= S_SEND;
          r_idx    <= '0;
          b        <= w_rd_word;
          checksum <= checksum + w_rd_ext;
        end
        S_SEND: begin
          if (w_last) begin
            r_state     <= S_DONE;
            b           <= '0;
            busy        <= 1'b0;
            coef_loaded <= 1'b1;
          end else begin
            r_idx    <= w_rd_idx;
            b        <= w_rd_word;
            checksum <= checksum + w_rd_ext;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
